rr_multi_issue_selector: RTL and testbench
==========================================

Name: rr_multi_issue_selector

Overview:
- Parametrised N-channel successor to the two-stage issue selector used by the reservation station.
- Each cycle, selects up to p_PORTS distinct ready entries from a p_SIZE request vector and routes one to each ready issue port.
- A registered rotating-priority pointer gives round-robin fairness, with a fixed-priority fallback mode.
- Sits between reservation-station ready bits and functional-unit issue ports.

Parameters:
p_SIZE, 8, number of request entries (2..64)
p_PORTS, 2, number of issue channels (1..4, p_PORTS <= p_SIZE)
p_RR, 1, 1 = round-robin pointer; 0 = fixed priority, pointer held at 0
p_PTR_W, clog2(p_SIZE), pointer width

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  global issue enable; 0 forces all grants to 0 and holds the pointer
req  input  p_SIZE  entry-ready vector
port_ready  input  p_PORTS  per-port functional unit can accept this cycle
gnt_bus  output  p_PORTS*p_SIZE  one-hot or zero grant per port; port k occupies bits [k*p_SIZE +: p_SIZE]
gnt_valid  output  p_PORTS  port k received a grant
load  output  p_SIZE  bitwise OR of all port grants
num_granted  output  clog2(p_PORTS+1)  population count of load
ptr  output  p_PTR_W  current priority pointer, for debug and verification

Behaviour:
- Grants are combinational from req, port_ready, enable and the registered ptr. Zero latency request-to-grant.
- Scan order starts at entry ptr and ascends through ptr+1 … p_SIZE-1, then wraps 0 … ptr-1.
- The j-th set req bit in scan order goes to the j-th port with port_ready=1, taken in ascending port index. Ports with port_ready=0 get a zero vector and do not consume a request.
- Granted entries are mutually exclusive across ports. load therefore has exactly num_granted bits set.
- num_granted = min(popcount(req), popcount(port_ready)) when enable=1. It is 0 otherwise.
- Pointer update on the rising clock edge, when p_RR=1, enable=1 and num_granted>0:
  - ptr <= (index of the last granted entry in scan order + 1) mod p_SIZE.
  - Wrap from p_SIZE-1 goes to 0.
- Otherwise ptr holds. When p_RR=0, ptr is constant 0. This gives fixed priority with the lowest index first.
- Reset (reset=0, asynchronous): ptr=0 immediately.
- Reset value of every output: gnt_bus, gnt_valid, load and num_granted track the combinational result of the inputs with ptr=0. With req=0 all are 0.
- Reset asserted mid-operation: the pointer drops to 0 in the same cycle. No stale grant state exists because no grant is registered.
- Boundaries:
  - req all ones with all ports ready: the lowest p_PORTS indices in scan order are granted.
  - req=0: no grants, ptr holds.
  - port_ready=0 on all ports: no grants, ptr holds.
  - Fewer requests than ready ports: the higher-indexed ready ports get no grant.
- No latches. All registers use the asynchronous active-low reset only.

Test Plan:
1. Defaults (p_SIZE=8, p_PORTS=2). Reset, then req=8'b1111_1111, port_ready=2'b11, enable=1 for 4 cycles:
   - Grant pairs are (0,1), (2,3), (4,5), (6,7).
   - ptr sequence is 0, 2, 4, 6, then 0.
2. Wrap-around. ptr=6, req=8'b1000_0001, both ports ready:
   - Port0 is granted entry 7 and port1 is granted entry 0; load=8'b1000_0001.
   - Next ptr=1.
3. Port stall. ptr=0, req=8'b0000_0110, port_ready=2'b10:
   - gnt_valid=2'b10 and port1 is granted entry 1.
   - Port0 gets a zero vector; num_granted=1; next ptr=2.
4. Idle and disable:
   - req=0 gives no grants and ptr holds.
   - enable=0 with req=8'hFF gives all grants 0 and ptr holds.
5. Fixed mode (p_RR=0). req=8'b0011_0000 repeated 3 cycles:
   - Every cycle grants entries 4 and 5, and ptr stays 0.
6. Asynchronous reset. ptr=5; assert reset low between clock edges:
   - ptr becomes 0 before the next edge.
   - Grants recompute from entry 0. With req=8'b0010_0001, entries 0 and 5 are granted.

Source files
------------

// File: rtl/rr_multi_issue_selector.sv
// Multi-port issue selector: picks up to p_PORTS ready entries per cycle in rotating
// scan order from a registered priority pointer, with a fixed-priority mode when p_RR=0.
module rr_multi_issue_selector #(
    parameter int p_SIZE  = 8,
    parameter int p_PORTS = 2,
    parameter int p_RR    = 1,
    parameter int p_PTR_W = $clog2(p_SIZE)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [p_SIZE-1:0]            req,
    input  logic [p_PORTS-1:0]           port_ready,
    output logic [p_PORTS*p_SIZE-1:0]    gnt_bus,
    output logic [p_PORTS-1:0]           gnt_valid,
    output logic [p_SIZE-1:0]            load,
    output logic [$clog2(p_PORTS+1)-1:0] num_granted,
    output logic [p_PTR_W-1:0]           ptr
);

    localparam int NG_W = $clog2(p_PORTS+1);
    localparam logic [p_PTR_W:0] SIZE_X = (p_PTR_W+1)'(p_SIZE);

    logic [p_SIZE-1:0]                req_rot;
    logic [p_PORTS-1:0][NG_W-1:0]     port_rank;
    logic [p_PORTS-1:0][p_SIZE-1:0]   gnt_rot;
    logic [p_PORTS-1:0][p_SIZE-1:0]   gnt_arr;
    logic [p_PTR_W-1:0]               last_rot;
    logic [p_PTR_W-1:0]               ptr_next;
    logic                             any_gnt;

    // Rotate so that index 0 of req_rot is the entry at ptr; scan order is then ascending.
    assign req_rot = p_SIZE'({req, req} >> ptr);

    // Handshake: port_ready[k]=1 means port k accepts a grant this cycle; a grant is
    // issued (gnt_valid[k]=1) only in such a cycle, and is not held or registered.
    always_comb begin : rank_calc
        int r;
        r = 0;
        port_rank = '0;
        for (int k = 0; k < p_PORTS; k++) begin
            port_rank[k] = NG_W'(r);
            if (port_ready[k]) r++;
        end
    end

    // The j-th requesting entry in scan order goes to the ready port of rank j.
    always_comb begin : select
        int   cnt;
        logic hit;
        cnt      = 0;
        hit      = 1'b0;
        gnt_rot  = '0;
        last_rot = '0;
        for (int i = 0; i < p_SIZE; i++) begin
            if (enable && req_rot[i]) begin
                hit = 1'b0;
                for (int k = 0; k < p_PORTS; k++) begin
                    if (port_ready[k] && int'(port_rank[k]) == cnt) begin
                        gnt_rot[k][i] = 1'b1;
                        hit           = 1'b1;
                    end
                end
                if (hit) begin
                    cnt++;
                    last_rot = p_PTR_W'(i);
                end
            end
        end
        num_granted = NG_W'(cnt);
    end

    always_comb begin : unrotate
        logic [2*p_SIZE-1:0] dbl;
        dbl     = '0;
        gnt_arr = '0;
        for (int k = 0; k < p_PORTS; k++) begin
            dbl        = {gnt_rot[k], gnt_rot[k]} << ptr;
            gnt_arr[k] = dbl[2*p_SIZE-1:p_SIZE];
        end
    end

    always_comb begin : outputs
        load      = '0;
        gnt_valid = '0;
        for (int k = 0; k < p_PORTS; k++) begin
            load         = load | gnt_arr[k];
            gnt_valid[k] = |gnt_arr[k];
        end
    end

    assign gnt_bus = gnt_arr;
    assign any_gnt = |gnt_valid;

    always_comb begin : next_ptr
        logic [p_PTR_W:0] sum;
        sum = {1'b0, ptr} + {1'b0, last_rot} + (p_PTR_W+1)'(1);
        if (sum >= SIZE_X) sum = sum - SIZE_X;
        ptr_next = sum[p_PTR_W-1:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (p_RR != 0 && any_gnt) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: tb/tb_rr_multi_issue_selector.sv
// Bench for rr_multi_issue_selector: a round-robin and a fixed-priority instance share
// inputs; a scan-order reference model is compared every cycle, plus literal directed checks.
module tb_rr_multi_issue_selector;

    localparam int S = 8;
    localparam int P = 2;

    logic         clock;
    logic         reset;
    logic         enable;
    logic [S-1:0] req;
    logic [P-1:0] port_ready;

    logic [P*S-1:0] rr_gnt_bus, fx_gnt_bus;
    logic [P-1:0]   rr_gnt_valid, fx_gnt_valid;
    logic [S-1:0]   rr_load, fx_load;
    logic [1:0]     rr_num, fx_num;
    logic [2:0]     rr_ptr, fx_ptr;

    int n_checks = 0;
    int n_errors = 0;
    int m_ptr    = 0;
    bit chk_en   = 0;

    rr_multi_issue_selector #(.p_SIZE(S), .p_PORTS(P), .p_RR(1)) dut_rr (
        .clock(clock), .reset(reset), .enable(enable), .req(req), .port_ready(port_ready),
        .gnt_bus(rr_gnt_bus), .gnt_valid(rr_gnt_valid), .load(rr_load),
        .num_granted(rr_num), .ptr(rr_ptr)
    );

    rr_multi_issue_selector #(.p_SIZE(S), .p_PORTS(P), .p_RR(0)) dut_fx (
        .clock(clock), .reset(reset), .enable(enable), .req(req), .port_ready(port_ready),
        .gnt_bus(fx_gnt_bus), .gnt_valid(fx_gnt_valid), .load(fx_load),
        .num_granted(fx_num), .ptr(fx_ptr)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    // List requesting entries in scan order and ready ports in index order, then zip.
    function automatic void model(input logic [S-1:0] r, input logic [P-1:0] pr, input logic e,
                                  input int p, output logic [P*S-1:0] gb, output logic [P-1:0] gv,
                                  output logic [S-1:0] ld, output int ng, output int nxt);
        int ents[$];
        int ports[$];
        gb = '0; gv = '0; ld = '0; nxt = p;
        for (int i = 0; i < S; i++) if (r[(p + i) % S]) ents.push_back((p + i) % S);
        for (int k = 0; k < P; k++) if (pr[k]) ports.push_back(k);
        ng = 0;
        if (e) ng = (ents.size() < ports.size()) ? ents.size() : ports.size();
        for (int j = 0; j < ng; j++) begin
            gb[ports[j]*S + ents[j]] = 1'b1;
            gv[ports[j]]             = 1'b1;
            ld[ents[j]]              = 1'b1;
            nxt                      = (ents[j] + 1) % S;
        end
    endfunction

    always @(posedge clock or negedge reset) begin : model_ptr
        logic [P*S-1:0] gb;
        logic [P-1:0]   gv;
        logic [S-1:0]   ld;
        int             ng, nxt;
        if (!reset) begin
            m_ptr <= 0;
        end else begin
            model(req, port_ready, enable, m_ptr, gb, gv, ld, ng, nxt);
            m_ptr <= nxt;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin : compare
        logic [P*S-1:0] gb;
        logic [P-1:0]   gv;
        logic [S-1:0]   ld;
        int             ng, nxt;
        if (chk_en) begin
            model(req, port_ready, enable, m_ptr, gb, gv, ld, ng, nxt);
            check("rr_gnt_bus",   32'(rr_gnt_bus),   32'(gb));
            check("rr_gnt_valid", 32'(rr_gnt_valid), 32'(gv));
            check("rr_load",      32'(rr_load),      32'(ld));
            check("rr_num",       32'(rr_num),       32'(ng));
            check("rr_ptr",       32'(rr_ptr),       32'(m_ptr));
            model(req, port_ready, enable, 0, gb, gv, ld, ng, nxt);
            check("fx_gnt_bus",   32'(fx_gnt_bus),   32'(gb));
            check("fx_gnt_valid", 32'(fx_gnt_valid), 32'(gv));
            check("fx_load",      32'(fx_load),      32'(ld));
            check("fx_num",       32'(fx_num),       32'(ng));
            check("fx_ptr",       32'(fx_ptr),       32'd0);
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic [S-1:0] r, input logic [P-1:0] pr, input logic e);
        @(posedge clock);
        #1;
        req        = r;
        port_ready = pr;
        enable     = e;
        @(negedge clock);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        #1 reset = 1'b0;
        #2 reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; req = '0; port_ready = '0; enable = 1'b0;
        #1 chk_en = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_ptr", 32'(rr_ptr), 32'd0);
        check("reset_gnt", 32'(rr_gnt_bus), 32'h0);
        #1 reset = 1'b1;

        // all requests, both ports ready: pairs advance through the vector
        drive(8'hFF, 2'b11, 1'b1);
        check("t1_gnt0", 32'(rr_gnt_bus), 32'h0201);
        check("t1_ptr0", 32'(rr_ptr), 32'd0);
        check("t1_num0", 32'(rr_num), 32'd2);
        drive(8'hFF, 2'b11, 1'b1);
        check("t1_gnt1", 32'(rr_gnt_bus), 32'h0804);
        check("t1_ptr1", 32'(rr_ptr), 32'd2);
        drive(8'hFF, 2'b11, 1'b1);
        check("t1_gnt2", 32'(rr_gnt_bus), 32'h2010);
        check("t1_ptr2", 32'(rr_ptr), 32'd4);
        drive(8'hFF, 2'b11, 1'b1);
        check("t1_gnt3", 32'(rr_gnt_bus), 32'h8040);
        check("t1_ptr3", 32'(rr_ptr), 32'd6);
        drive(8'h00, 2'b11, 1'b1);
        check("t1_wrap_ptr", 32'(rr_ptr), 32'd0);
        check("idle_num", 32'(rr_num), 32'd0);

        // walk the pointer back to 6, then wrap-around grant
        repeat (3) drive(8'hFF, 2'b11, 1'b1);
        drive(8'h81, 2'b11, 1'b1);
        check("t2_ptr", 32'(rr_ptr), 32'd6);
        check("t2_gnt", 32'(rr_gnt_bus), 32'h0180);
        check("t2_load", 32'(rr_load), 32'h81);
        drive(8'h00, 2'b11, 1'b1);
        check("t2_next_ptr", 32'(rr_ptr), 32'd1);
        drive(8'h00, 2'b11, 1'b1);
        check("t4_idle_hold", 32'(rr_ptr), 32'd1);
        drive(8'hFF, 2'b11, 1'b0);
        check("t4_dis_gnt", 32'(rr_gnt_bus), 32'h0);
        check("t4_dis_num", 32'(rr_num), 32'd0);
        drive(8'h00, 2'b11, 1'b1);
        check("t4_dis_hold", 32'(rr_ptr), 32'd1);
        drive(8'hFF, 2'b00, 1'b1);
        check("noport_gnt", 32'(rr_gnt_bus), 32'h0);
        drive(8'h00, 2'b11, 1'b1);
        check("noport_hold", 32'(rr_ptr), 32'd1);

        // port stall: only port 1 ready
        pulse_reset();
        drive(8'h06, 2'b10, 1'b1);
        check("t3_ptr", 32'(rr_ptr), 32'd0);
        check("t3_gnt", 32'(rr_gnt_bus), 32'h0200);
        check("t3_valid", 32'(rr_gnt_valid), 32'h2);
        check("t3_num", 32'(rr_num), 32'd1);
        drive(8'h00, 2'b11, 1'b1);
        check("t3_next_ptr", 32'(rr_ptr), 32'd2);

        // fixed priority instance
        repeat (3) begin
            drive(8'h30, 2'b11, 1'b1);
            check("t5_fx_gnt", 32'(fx_gnt_bus), 32'h2010);
            check("t5_fx_ptr", 32'(fx_ptr), 32'd0);
        end

        // asynchronous reset between edges
        pulse_reset();
        drive(8'h10, 2'b11, 1'b1);
        drive(8'h21, 2'b11, 1'b1);
        check("t6_ptr5", 32'(rr_ptr), 32'd5);
        check("t6_gnt_pre", 32'(rr_gnt_bus), 32'h0120);
        #1 reset = 1'b0;
        #1;
        check("t6_async_ptr", 32'(rr_ptr), 32'd0);
        check("t6_gnt_post", 32'(rr_gnt_bus), 32'h2001);
        #1 reset = 1'b1;

        // randomized traffic against the model
        repeat (400) begin
            logic [S-1:0] r;
            r = S'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) r = r & S'($urandom_range(0, 255));
            drive(r, P'($urandom_range(0, 3)), $urandom_range(0, 7) != 0);
        end

        @(posedge clock);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
